instr_fetch_mem: RTL
====================

Name: instr_fetch_mem

Overview:
Instruction-memory responder on the fetch side of the P5 pipeline: it consumes the byte PC driven by the program counter and returns the addressed 32-bit instruction through an IF/ID-facing output register.
- Bounds-checks the PC and reports misaligned or out-of-range fetches.
- Honours stall and flush from the hazard unit.
- Provides a loader write port so the boot/test image can be written into the array.

Parameters:
BASE_ADDR, 32'h0000_3000, byte address mapped to word 0 of the array
DEPTH_LOG2, 12, log2 of array depth in 32-bit words (default 4096 words = 16 KiB)
NOP_WORD, 32'h0000_0000, instruction emitted on fault, flush and reset

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high reset
pc_i  in  32  byte fetch address from PC
pc_valid_i  in  1  fetch request this cycle
stall_i  in  1  hold outputs (IF/ID stall)
flush_i  in  1  squash the registered instruction (IF/ID flush)
ld_we_i  in  1  loader write enable
ld_addr_i  in  DEPTH_LOG2  loader word index
ld_data_i  in  32  loader write data
instr_o  out  32  registered instruction
pc_o  out  32  PC belonging to instr_o
instr_valid_o  out  1  instr_o holds a real fetched instruction
fault_o  out  1  registered fetch fault
fault_code_o  out  2  00 none, 01 misaligned, 10 out of range

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values (one edge with reset=1):
  - instr_o=NOP_WORD, pc_o=BASE_ADDR, instr_valid_o=0, fault_o=0, fault_code_o=00.
  - Array contents are NOT cleared.
  - Reset has priority over flush_i, stall_i, pc_valid_i and any in-flight fetch.
  - Loader writes in the reset cycle still commit.
- Index computation: off = pc_i - BASE_ADDR (32-bit unsigned wrap); index = off[DEPTH_LOG2+1:2].
- Fault classification (combinational on pc_i):
  - Misaligned if pc_i[1:0] != 0 (code 01).
  - Else out of range if pc_i < BASE_ADDR or off >= 4*2^DEPTH_LOG2 (code 10).
  - Misaligned takes priority over out of range.
- Latency: exactly 1 cycle; values presented before edge N appear on outputs after edge N.
- Per-edge update priority (highest first): reset > flush_i > stall_i > pc_valid_i.
  - flush_i=1: instr_o=NOP_WORD, instr_valid_o=0, fault_o=0, fault_code_o=00, pc_o=pc_i. Flush wins over stall.
  - stall_i=1 (no flush): all outputs hold their current values.
  - pc_valid_i=1 with fault: instr_o=NOP_WORD, instr_valid_o=0, fault_o=1, fault_code_o=code, pc_o=pc_i.
  - pc_valid_i=1, no fault: instr_o=mem[index], instr_valid_o=1, fault_o=0, fault_code_o=00, pc_o=pc_i.
  - pc_valid_i=0: instr_o=NOP_WORD, instr_valid_o=0, fault_o=0, fault_code_o=00; pc_o holds.
- Loader port:
  - ld_we_i=1 writes mem[ld_addr_i]=ld_data_i at the edge.
  - Writes are independent of stall/flush/fetch.
- Read-during-write: fetch index equals ld_addr_i with ld_we_i=1 in the same cycle -> instr_o returns ld_data_i (write-first).
- Boundary: last valid word is BASE_ADDR + 4*(2^DEPTH_LOG2 - 1) = 0x6FFC at defaults; 0x7000 faults with code 10; 0x2FFC faults with code 10.
- fault_o is registered per fetch, not sticky; it clears on the next non-faulting update.

Test Plan:
- Reset then loader writes mem[0]=0x3C01_1234, mem[1]=0x3421_5678; fetch pc_i=0x3000 then 0x3004 -> instr_o=0x3C011234 then 0x34215678 one cycle after each; instr_valid_o=1; pc_o tracks.
- Fetch 0x6FFC after loading mem[4095]=0xDEADBEEF -> 0xDEADBEEF, valid=1; fetch 0x7000 -> NOP, fault_o=1, code 10; fetch 0x2FFC -> code 10; fetch 0x3002 -> code 01; fetch 0x1 -> code 01 (misaligned priority).
- stall_i=1 for 3 cycles while pc_i changes 0x3000→0x3004→0x3008 -> outputs hold the pre-stall value; stall_i=1 with flush_i=1 -> NOP, valid=0 next cycle.
- ld_we_i=1, ld_addr_i=2, ld_data_i=0xAAAA5555 in the same cycle as fetch of 0x3008 -> instr_o=0xAAAA5555.
- Assert reset mid-stream after a faulting fetch -> next cycle instr_o=0, pc_o=0x3000, valid=0, fault_o=0; previously loaded mem[0] still readable afterwards.
- pc_valid_i=0 for one cycle between valid fetches -> instr_valid_o=0, instr_o=NOP for that cycle, pc_o holds the previous value.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
//
// Instruction memory on the fetch side of the pipeline. Takes the byte PC from
// the program counter, bounds-checks it, and returns the addressed 32-bit
// instruction through an output register that feeds IF/ID. A loader port
// writes the boot/test image into the array.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   pc_i           in   byte fetch address
//   pc_valid_i     in   fetch request this cycle
//   stall_i        in   hold all outputs (IF/ID stall)
//   flush_i        in   squash the registered instruction (IF/ID flush)
//   ld_we_i        in   loader write enable
//   ld_addr_i      in   loader word index
//   ld_data_i      in   loader write data
//   instr_o        out  registered instruction
//   pc_o           out  PC belonging to instr_o
//   instr_valid_o  out  instr_o holds a real fetched instruction
//   fault_o        out  registered fetch fault
//   fault_code_o   out  00 none, 01 misaligned, 10 out of range
// ---------------------------------------------------------------------------
module instr_fetch_mem #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pc_i,
   input  logic                  pc_valid_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  ld_we_i,
   input  logic [DEPTH_LOG2-1:0] ld_addr_i,
   input  logic [31:0]           ld_data_i,
   output logic [31:0]           instr_o,
   output logic [31:0]           pc_o,
   output logic                  instr_valid_o,
   output logic                  fault_o,
   output logic [1:0]            fault_code_o
);

   localparam int          DEPTH = 1 << DEPTH_LOG2;
   // Byte span of the array; 33 bits so the compare cannot overflow.
   localparam logic [32:0] SPAN  = 33'd1 << (DEPTH_LOG2 + 2);

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_ALIGN = 2'b01;
   localparam logic [1:0] CODE_RANGE = 2'b10;

   logic [31:0] mem [0:DEPTH-1];

   logic [31:0]           off;
   logic [DEPTH_LOG2-1:0] index;
   logic [1:0]            code_next;
   logic [31:0]           rd_data;

   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic        valid_reg;
   logic        fault_reg;
   logic [1:0]  code_reg;

   // Offset wraps for PCs below BASE_ADDR; those are caught explicitly below.
   assign off   = pc_i - BASE_ADDR;
   assign index = off[DEPTH_LOG2+1:2];

   always_comb begin
      code_next = CODE_NONE;
      if (pc_i[1:0] != 2'b00)
         code_next = CODE_ALIGN;
      else if ((pc_i < BASE_ADDR) || ({1'b0, off} >= SPAN))
         code_next = CODE_RANGE;
   end

   // Write-first: a loader write to the word being fetched is seen this cycle.
   assign rd_data = (ld_we_i && (ld_addr_i == index)) ? ld_data_i : mem[index];

   // Array write path is independent of reset, stall and flush.
   always_ff @(posedge clk) begin
      if (ld_we_i)
         mem[ld_addr_i] <= ld_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_reg <= NOP_WORD;
         pc_reg    <= BASE_ADDR;
         valid_reg <= 1'b0;
         fault_reg <= 1'b0;
         code_reg  <= CODE_NONE;
      end else if (flush_i) begin
         instr_reg <= NOP_WORD;
         pc_reg    <= pc_i;
         valid_reg <= 1'b0;
         fault_reg <= 1'b0;
         code_reg  <= CODE_NONE;
      end else if (stall_i) begin
         instr_reg <= instr_reg;
         pc_reg    <= pc_reg;
         valid_reg <= valid_reg;
         fault_reg <= fault_reg;
         code_reg  <= code_reg;
      end else if (pc_valid_i) begin
         pc_reg <= pc_i;
         if (code_next != CODE_NONE) begin
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
            fault_reg <= 1'b1;
            code_reg  <= code_next;
         end else begin
            instr_reg <= rd_data;
            valid_reg <= 1'b1;
            fault_reg <= 1'b0;
            code_reg  <= CODE_NONE;
         end
      end else begin
         // Bubble: PC holds so downstream still knows where fetch stopped.
         instr_reg <= NOP_WORD;
         pc_reg    <= pc_reg;
         valid_reg <= 1'b0;
         fault_reg <= 1'b0;
         code_reg  <= CODE_NONE;
      end
   end

   assign instr_o       = instr_reg;
   assign pc_o          = pc_reg;
   assign instr_valid_o = valid_reg;
   assign fault_o       = fault_reg;
   assign fault_code_o  = code_reg;

endmodule
